// File: rtl/subshift.sv
// AES SubBytes+ShiftRows round stage: four computed S-box lanes, one state row per cycle.
// Encrypt applies the forward S-box then rotates rows left; decrypt rotates rows right, then applies the inverse S-box.
module subshift (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] data_in,
  input  logic         start_in,
  input  logic         en_de,
  output logic [127:0] data_out,
  output logic         ready_out
);

  localparam int unsigned W     = 128;
  localparam int unsigned RW    = 32;
  localparam int unsigned LANES = 4;

  typedef enum logic {IDLE, BUSY} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // x^254 via an addition chain; zero maps to zero naturally
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  function automatic logic [7:0] aff_fwd(input logic [7:0] b);
    return b ^ {b[3:0], b[7:4]} ^ {b[4:0], b[7:5]} ^ {b[5:0], b[7:6]}
             ^ {b[6:0], b[7]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] aff_inv(input logic [7:0] b);
    return {b[1:0], b[7:2]} ^ {b[4:0], b[7:5]} ^ {b[6:0], b[7]} ^ 8'h05;
  endfunction

  state_e         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [W-1:0]   src_q, src_d;
  logic           enc_q, enc_d;
  logic [W-1:0]   res_q, res_d;
  logic [W-1:0]   out_q, out_d;
  logic           ready_q, ready_d;

  logic [RW-1:0]  row_raw;
  logic [RW-1:0]  row_rot;
  logic [RW-1:0]  row_res;

  // Row select and byte rotation; the S-box is bytewise so rotating before it is equivalent
  always_comb begin
    row_raw = src_q[127:96];
    case (cnt_q)
      2'd0: row_raw = src_q[127:96];
      2'd1: row_raw = src_q[95:64];
      2'd2: row_raw = src_q[63:32];
      2'd3: row_raw = src_q[31:0];
      default: row_raw = src_q[127:96];
    endcase
    row_rot = row_raw;
    case (cnt_q)
      2'd1: row_rot = enc_q ? {row_raw[23:0], row_raw[31:24]} : {row_raw[7:0], row_raw[31:8]};
      2'd2: row_rot = {row_raw[15:0], row_raw[31:16]};
      2'd3: row_rot = enc_q ? {row_raw[7:0], row_raw[31:8]} : {row_raw[23:0], row_raw[31:24]};
      default: row_rot = row_raw;
    endcase
  end

  // Four S-box lanes sharing one field inverter each between the two directions
  always_comb begin
    row_res = '0;
    for (int l = 0; l < LANES; l++) begin
      logic [7:0] b;
      logic [7:0] y;
      b = row_rot[8*l +: 8];
      y = gf_inv(enc_q ? b : aff_inv(b));
      row_res[8*l +: 8] = enc_q ? aff_fwd(y) : y;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    enc_d   = enc_q;
    res_d   = res_q;
    out_d   = out_q;
    ready_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          src_d   = data_in;
          enc_d   = en_de;
          cnt_d   = 2'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        case (cnt_q)
          2'd0: res_d[127:96] = row_res;
          2'd1: res_d[95:64]  = row_res;
          2'd2: res_d[63:32]  = row_res;
          default: res_d[31:0] = row_res;
        endcase
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          out_d   = {res_q[127:32], row_res};
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      src_q   <= '0;
      enc_q   <= 1'b0;
      res_q   <= '0;
      out_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      enc_q   <= enc_d;
      res_q   <= res_d;
      out_q   <= out_d;
      ready_q <= ready_d;
    end
  end

  assign data_out  = out_q;
  assign ready_out = ready_q;

endmodule

// File: tb/tb_subshift.sv
// Self-checking bench for subshift: S-box tables built by brute-force inversion, per-byte row model, cycle-level completion model.
module tb_subshift;

  localparam logic [127:0] T1_IN  = 128'h19a09ae9_3df4c6f8_e3e28d48_be2b2a08;
  localparam logic [127:0] T1_OUT = 128'hd4e0b81e_bfb44127_5d521198_30aef1e5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] data_in = '0;
  logic         start_in = 1'b0;
  logic         en_de = 1'b0;
  logic [127:0] data_out;
  logic         ready_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] sbox [256];
  logic [7:0] isbox[256];

  subshift dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .start_in (start_in),
    .en_de    (en_de),
    .data_out (data_out),
    .ready_out(ready_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    int acc = 0;
    int aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = aa << 1;
      if (aa >= 256) aa = aa ^ 'h11b;
    end
    return 8'(acc);
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, r;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        r[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ (((8'h63 >> i) & 8'h01) != 0);
      sbox[x] = r;
    end
    for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);
  endtask

  // Output byte (r,c): enc takes S(in[r][(c+r)%4]), dec takes InvS(in[r][(c-r)%4])
  function automatic logic [127:0] model_out(input logic [127:0] d, input logic enc);
    logic [7:0] s[4][4];
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = d[127 - 32*r - 8*c -: 8];
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127 - 32*r - 8*c -: 8] = enc ? sbox[s[r][(c+r)%4]] : isbox[s[r][(c+4-r)%4]];
    return o;
  endfunction

  logic [127:0] exp_data;
  logic         exp_ready;
  logic [127:0] m_result;
  int           m_left;

  // Block accepted when idle completes four edges later; starts during that window are dropped
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_data  = '0;
      exp_ready = 1'b0;
      m_left    = 0;
    end else begin
      exp_ready = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          exp_data  = m_result;
          exp_ready = 1'b1;
        end
      end else if (start_in) begin
        m_result = model_out(data_in, en_de);
        m_left   = 4;
      end
    end
  end

  always @(negedge clk) begin
    chk("ready_out_cycle", 128'(ready_out), 128'(exp_ready));
    chk("data_out_cycle", data_out, exp_data);
  end

  task automatic start_block(input logic [127:0] d, input logic enc);
    data_in  = d;
    en_de    = enc;
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready_out && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (!ready_out) begin
      errors++;
      $display("FAIL ready_timeout: got no ready_out within %0d cycles, required a pulse", n);
    end
  endtask

  task automatic run_check(input string name, input logic [127:0] d, input logic enc,
                           input logic [127:0] exp);
    int n;
    start_block(d, enc);
    wait_ready(n);
    chk({name, "_latency"}, 128'(n), 128'(4));
    chk({name, "_data"}, data_out, exp);
  endtask

  initial begin
    int n;
    int pulses;
    build_tables();

    chk("model_t1_enc", model_out(T1_IN, 1'b1), T1_OUT);
    chk("model_t2_dec", model_out(T1_OUT, 1'b0), T1_IN);
    chk("model_sbox_53", 128'(sbox[8'h53]), 128'(8'hed));

    repeat (2) @(negedge clk);
    chk("reset_data_out", data_out, '0);
    chk("reset_ready_out", 128'(ready_out), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    run_check("t1_enc", T1_IN, 1'b1, T1_OUT);
    @(negedge clk);
    chk("ready_one_cycle", 128'(ready_out), 128'(0));
    run_check("t2_dec", T1_OUT, 1'b0, T1_IN);
    run_check("t3_enc_00", {16{8'h00}}, 1'b1, {16{8'h63}});
    run_check("t3_enc_53", {16{8'h53}}, 1'b1, {16{8'hed}});
    run_check("t3_dec_63", {16{8'h63}}, 1'b0, {16{8'h00}});
    run_check("t3_dec_ed", {16{8'hed}}, 1'b0, {16{8'h53}});

    // Re-pulse sampled at E2 with other data and direction must be ignored
    @(negedge clk);
    start_block(T1_IN, 1'b1);
    data_in = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    en_de   = 1'b0;
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    wait_ready(n);
    chk("t4_latency", 128'(n), 128'(3));
    chk("t4_data", data_out, T1_OUT);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ready_out) pulses++;
    end
    chk("t4_extra_pulses", 128'(pulses), 128'(0));

    // Back-to-back: second start in the ready_out cycle
    start_block(T1_IN, 1'b1);
    wait_ready(n);
    chk("t5_first", data_out, T1_OUT);
    start_block(T1_OUT, 1'b0);
    wait_ready(n);
    chk("t5_gap", 128'(n + 1), 128'(5));
    chk("t5_second", data_out, T1_IN);

    // Reset in the middle of a block
    @(negedge clk);
    start_block(T1_IN, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_data", data_out, '0);
    chk("t6_rst_ready", 128'(ready_out), 128'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ready_out) pulses++;
    end
    chk("t6_no_pulse", 128'(pulses), 128'(0));
    run_check("t6_fresh", T1_IN, 1'b1, T1_OUT);

    // Random traffic: starts at random times, inputs churning while busy
    pulses = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (ready_out) pulses++;
      start_in = ($urandom_range(0, 2) == 0);
      data_in  = {$urandom, $urandom, $urandom, $urandom};
      en_de    = 1'($urandom_range(0, 1));
    end
    start_in = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (pulses < 20) begin
      errors++;
      $display("FAIL random_activity: got %0d completions, required at least 20", pulses);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
